qar_can_tx: RTL and testbench

Classic CAN 2.0A frame transmitter for the QAR-Core CAN peripheral. It is the transmit-side counterpart of the core's CAN receive path. It accepts one frame at a time from the register interface: 11-bit ID, DLC, and two 32-bit payload words. It serialises the frame onto `can_tx` with CRC-15 and bit stuffing, monitors `can_rx` for arbitration and ACK, and reports completion status. It sits between the CAN register block and the external transceiver, or the internal loopback used by the CAN demo.

---
 rtl/qar_can_pkg.sv | 27 ++
 rtl/qar_can_crc15.sv | 23 ++
 rtl/qar_can_tx.sv | 199 +++++++++++++++++++
 tb/tb_qar_can_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qar_can_pkg.sv
// Shared definitions for the QAR-Core CAN transmit and receive paths:
// FSM states, CRC-15 polynomial and CAN 2.0A field sizes.
package qar_can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } can_state_e;

  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int CRC_W     = 15;
  localparam int EOF_LEN   = 7;
  localparam int IFS_LEN   = 3;
  localparam int STUFF_RUN = 5;

  localparam logic [CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

endpackage

// File: rtl/qar_can_crc15.sv
// Serial CAN CRC-15 engine, one bit per enable; clear has priority over update.
module qar_can_crc15
  import qar_can_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bit_in) ? CAN_CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/qar_can_tx.sv
// CAN 2.0A frame transmitter with CRC-15, bit stuffing and ACK check.
// Define QAR_CAN_TX_ARB_EN to enable arbitration monitoring on can_rx.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for tx_valid, can_tx recessive
// ST_ARB     | SOF, ID[10:0], RTR (idx 0..12)
// ST_CTRL    | IDE, r0, DLC[3:0] (idx 0..5)
// ST_DATA    | min(DLC,8) payload bytes, MSB first
// ST_CRC     | CRC[14:0]
// ST_CRC_DEL | CRC delimiter
// ST_ACK     | ACK slot, can_rx sampled for acknowledge
// ST_ACK_DEL | ACK delimiter
// ST_EOF     | 7 recessive bits, done on the last cycle
// ST_IFS     | 3 recessive bits before returning to idle
module qar_can_tx
  import qar_can_pkg::*;
#(
  parameter int BIT_CLKS  = 16,
  parameter int SAMPLE_PT = BIT_CLKS / 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [ID_W-1:0]  tx_id,
  input  logic [DLC_W-1:0] tx_dlc,
  input  logic [31:0]      tx_data0,
  input  logic [31:0]      tx_data1,
  output logic             can_tx,
  input  logic             can_rx,
  output logic             busy,
  output logic             done,
  output logic             ack_err,
  output logic             arb_lost
);

  localparam int CW = $clog2(BIT_CLKS);

  can_state_e       state, state_nxt, adv_state;
  logic [6:0]       idx, idx_nxt, adv_idx;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [2:0]       run, run_nxt;
  logic             stuffed, stuffed_nxt;
  logic             tx_nxt, adv_bit;
  logic [ID_W-1:0]  id_q;
  logic [DLC_W-1:0] dlc_q;
  logic [63:0]      data_q;
  logic [6:0]       data_bits;
  logic [CRC_W-1:0] crc;
  logic             crc_clr, crc_en;
  logic             accept, bit_end, sample, in_region, lost_now;

  assign accept    = tx_valid && (state == ST_IDLE);
  assign bit_end   = (cnt == CW'(BIT_CLKS - 1));
  assign sample    = (cnt == CW'(SAMPLE_PT));
  assign in_region = state inside {ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  assign data_bits = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};
  assign tx_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = bit_end && (((state == ST_EOF) && (idx == 7'(EOF_LEN - 1))) || lost_now);

  qar_can_crc15 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (adv_bit),
    .crc    (crc)
  );

  // Next field position after the last non-stuff bit, and its bus value.
  always_comb begin
    adv_state = state;
    adv_idx   = idx + 7'd1;
    case (state)
      ST_ARB:     if (idx == 7'd12) begin adv_state = ST_CTRL; adv_idx = '0; end
      ST_CTRL:    if (idx == 7'd5) begin
                    adv_state = (data_bits == 7'd0) ? ST_CRC : ST_DATA;
                    adv_idx   = '0;
                  end
      ST_DATA:    if (idx == data_bits - 7'd1) begin adv_state = ST_CRC; adv_idx = '0; end
      ST_CRC:     if (idx == 7'(CRC_W - 1)) begin adv_state = ST_CRC_DEL; adv_idx = '0; end
      ST_CRC_DEL: begin adv_state = ST_ACK; adv_idx = '0; end
      ST_ACK:     begin adv_state = ST_ACK_DEL; adv_idx = '0; end
      ST_ACK_DEL: begin adv_state = ST_EOF; adv_idx = '0; end
      ST_EOF:     if (idx == 7'(EOF_LEN - 1)) begin adv_state = ST_IFS; adv_idx = '0; end
      ST_IFS:     if (idx == 7'(IFS_LEN - 1)) begin adv_state = ST_IDLE; adv_idx = '0; end
      default:    adv_idx = '0;
    endcase

    adv_bit = 1'b1;
    case (adv_state)
      ST_ARB:  adv_bit = (adv_idx != 7'd0 && adv_idx <= 7'd11) ? id_q[4'(7'd11 - adv_idx)] : 1'b0;
      ST_CTRL: adv_bit = (adv_idx < 7'd2) ? 1'b0 : dlc_q[2'(7'd5 - adv_idx)];
      ST_DATA: adv_bit = data_q[6'(7'd63 - adv_idx)];
      ST_CRC:  adv_bit = crc[4'(7'd14 - adv_idx)];
      default: adv_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_nxt     = cnt;
    tx_nxt      = can_tx;
    run_nxt     = run;
    stuffed_nxt = stuffed;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    if (accept) begin
      state_nxt   = ST_ARB;
      idx_nxt     = '0;
      cnt_nxt     = '0;
      tx_nxt      = 1'b0;
      run_nxt     = 3'd1;
      stuffed_nxt = 1'b0;
      crc_clr     = 1'b1;
    end else if (state != ST_IDLE) begin
      cnt_nxt = bit_end ? '0 : cnt + CW'(1);
      if (bit_end) begin
        if (lost_now) begin
          state_nxt   = ST_IFS;
          idx_nxt     = '0;
          tx_nxt      = 1'b1;
          stuffed_nxt = 1'b0;
        end else if (in_region && run == 3'(STUFF_RUN)) begin
          // Stuff bit: field position holds, the complement starts a new run.
          tx_nxt      = ~can_tx;
          run_nxt     = 3'd1;
          stuffed_nxt = 1'b1;
        end else begin
          state_nxt   = adv_state;
          idx_nxt     = adv_idx;
          tx_nxt      = adv_bit;
          stuffed_nxt = 1'b0;
          run_nxt     = (adv_bit == can_tx) ? run + 3'd1 : 3'd1;
          crc_en      = adv_state inside {ST_ARB, ST_CTRL, ST_DATA};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      can_tx  <= 1'b1;
      run     <= '0;
      stuffed <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      can_tx  <= tx_nxt;
      run     <= run_nxt;
      stuffed <= stuffed_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      dlc_q   <= '0;
      data_q  <= '0;
      ack_err <= 1'b0;
    end else if (accept) begin
      id_q    <= tx_id;
      dlc_q   <= tx_dlc;
      data_q  <= {tx_data0, tx_data1};
      ack_err <= 1'b0;
    end else if (sample && state == ST_ACK) begin
      ack_err <= can_rx;
    end
  end

`ifdef QAR_CAN_TX_ARB_EN
  logic lost_q;

  // Only real ID/RTR bits arbitrate; SOF and stuff bits are not compared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_q <= 1'b0;
    end else if (accept) begin
      lost_q <= 1'b0;
    end else if (sample && state == ST_ARB && !stuffed && idx != 7'd0 && can_tx && !can_rx) begin
      lost_q <= 1'b1;
    end
  end

  assign lost_now = lost_q && (state == ST_ARB);
  assign arb_lost = lost_q;
`else
  assign lost_now = 1'b0;
  assign arb_lost = 1'b0;
`endif

endmodule

// File: tb/tb_qar_can_tx.sv
// Scoreboard bench for qar_can_tx: a reference frame builder queues the
// expected bus bits, which are popped and compared as the DUT transmits.
module tb_qar_can_tx;

  localparam int BC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [31:0] tx_data0, tx_data1;
  logic        can_tx, can_rx, busy, done, ack_err, arb_lost;
  logic        force_dom;

  int n_checks = 0;
  int n_errors = 0;

  bit exp_q[$];
  int exp_done, exp_ready, id9_pos, n_stuffed, dom_a, dom_b;

  always #5 clk = ~clk;

  assign can_rx = force_dom ? 1'b0 : can_tx;

  qar_can_tx #(.BIT_CLKS(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_id    (tx_id),
    .tx_dlc   (tx_dlc),
    .tx_data0 (tx_data0),
    .tx_data1 (tx_data1),
    .can_tx   (can_tx),
    .can_rx   (can_rx),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .arb_lost (arb_lost)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: raw field bits, CRC-15 over SOF..data, then stuffing over SOF..CRC.
  task automatic build_frame(input logic [10:0] id, input logic [3:0] dlc,
                             input logic [63:0] data, input bit lose);
    bit raw[$];
    bit stf[$];
    logic [14:0] crc;
    int nb, run;
    bit last, nxt;
    crc = '0;
    run = 0;
    last = 1'b0;
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    repeat (3) raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = (dlc > 4'd8) ? 64 : int'(dlc) * 8;
    for (int i = 0; i < nb; i++) raw.push_back(data[63-i]);
    foreach (raw[i]) begin
      nxt = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    for (int i = 0; i < raw.size(); i++) begin
      if (i == 2) id9_pos = stf.size();
      stf.push_back(raw[i]);
      if (run > 0 && raw[i] == last) run++;
      else begin run = 1; last = raw[i]; end
      if (run == 5) begin
        stf.push_back(!raw[i]);
        last = !raw[i];
        run = 1;
      end
    end
    n_stuffed = stf.size();
    exp_q.delete();
    if (lose) begin
      for (int i = 0; i <= id9_pos; i++) exp_q.push_back(stf[i]);
      repeat (3) exp_q.push_back(1'b1);
      exp_done  = (id9_pos + 1) * BC - 1;
      exp_ready = (id9_pos + 4) * BC;
    end else begin
      foreach (stf[i]) exp_q.push_back(stf[i]);
      repeat (13) exp_q.push_back(1'b1);
      exp_done  = (n_stuffed + 10) * BC - 1;
      exp_ready = (n_stuffed + 13) * BC;
    end
  endtask

  // Cycle c = 0 is the SOF cycle (first negedge after the accepting edge).
  task automatic run_frame(input logic [10:0] id, input logic [3:0] dlc,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input bit ack, input bit force_arb,
                           input int poke_c, input int rst_c);
    int done_c, done_n, ready_c;
    bit b, lose, rst_hit;
`ifdef QAR_CAN_TX_ARB_EN
    lose = force_arb;
`else
    lose = 1'b0;
`endif
    build_frame(id, dlc, {d0, d1}, lose);
    dom_a   = force_arb ? id9_pos : -1;
    dom_b   = (ack && !lose) ? n_stuffed + 1 : -1;
    done_c  = -1;
    done_n  = 0;
    ready_c = -1;
    rst_hit = 1'b0;

    @(negedge clk);
    check("ready_before", tx_ready, 1'b1);
    tx_valid = 1'b1;
    tx_id    = id;
    tx_dlc   = dlc;
    tx_data0 = d0;
    tx_data1 = d1;
    @(posedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c == 0) begin
        tx_valid = 1'b0;
        tx_id    = ~id;
        tx_dlc   = ~dlc;
        tx_data0 = ~d0;
        tx_data1 = ~d1;
        check("sof_busy", busy, 1'b1);
        check("sof_ready", tx_ready, 1'b0);
        check("sof_ack_err", ack_err, 1'b0);
        check("sof_arb_lost", arb_lost, 1'b0);
      end
      if (c == poke_c) tx_valid = 1'b1;
      if (c == poke_c + 1) tx_valid = 1'b0;
      force_dom = ((c / BC) == dom_a) || ((c / BC) == dom_b);
      if (rst_c >= 0 && c >= rst_c && can_tx == 1'b0) begin
        rst = 1'b1;
        #1;
        check("rst_can_tx", can_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_done", done, 1'b0);
        rst_hit = 1'b1;
        force_dom = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (tx_ready) begin
        ready_c = c;
        break;
      end
      if (done) begin
        done_n++;
        done_c = c;
      end
      if (exp_q.size() > 0) begin
        if (c % BC == 0) check("bit_start", can_tx, exp_q[0]);
        if (c % BC == BC - 1) begin
          b = exp_q.pop_front();
          check("bit_end", can_tx, b);
        end
      end
    end
    force_dom = 1'b0;
    if (rst_c >= 0) begin
      check("rst_hit", rst_hit, 1'b1);
      return;
    end
    check("done_count", done_n, 1);
    check("done_cycle", done_c, exp_done);
    check("ready_cycle", ready_c, exp_ready);
    check("bits_left", exp_q.size(), 0);
    check("ack_err", ack_err, (!ack && !lose) ? 1'b1 : 1'b0);
    check("arb_lost", arb_lost, lose);
    check("idle_busy", busy, 1'b0);
    check("idle_can_tx", can_tx, 1'b1);
  endtask

  initial begin
    rst       = 1'b0;
    tx_valid  = 1'b0;
    tx_id     = '0;
    tx_dlc    = '0;
    tx_data0  = '0;
    tx_data1  = '0;
    force_dom = 1'b0;
    dom_a     = -1;
    dom_b     = -1;
    #1 rst = 1'b1;
    #1;
    check("reset_can_tx", can_tx, 1'b1);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ack_err", ack_err, 1'b0);
    check("reset_arb_lost", arb_lost, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_frame(11'h000, 4'd0,  32'h0,        32'h0,        1'b1, 1'b0, -1, -1);
    run_frame(11'h7FF, 4'd0,  32'h0,        32'h0,        1'b1, 1'b0, -1, -1);
    run_frame(11'h123, 4'd8,  32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, -1, -1);
    run_frame(11'h321, 4'd2,  32'hA5C30000, 32'h0,        1'b1, 1'b1, -1, -1);
    run_frame(11'h555, 4'd4,  32'h00000000, 32'h0,        1'b1, 1'b0, -1, 400);
    run_frame(11'h321, 4'd8,  32'hCAFEBABE, 32'h01020304, 1'b1, 1'b0, -1, -1);
    run_frame(11'h0A5, 4'd3,  32'h12345600, 32'h0,        1'b1, 1'b0, 100, -1);
    run_frame(11'h2B4, 4'd12, 32'h89ABCDEF, 32'h76543210, 1'b1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
